// File: rtl/add_i8_rr_sched_pkg.sv
// Shared types for the round-robin add_i8 scheduler.
// The tag id is sized for the largest supported requester count.
package add_sched_pkg;
  localparam int DATA_W  = 8;
  localparam int ID_MAXW = 3;

  typedef struct packed {
    logic               vld;
    logic [ID_MAXW-1:0] id;
  } tag_t;
endpackage

// File: rtl/add_i8_rr_sched_rr_grant.sv
// Combinational round-robin arbiter.
// Searches from ptr upward, wrapping modulo N.
module rr_grant_n #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/add_i8_rr_sched.sv
// Shares one external 8-bit adder among N requesters.
// Tags follow each op through the adder latency.
module add_i8_rr_sched
  import add_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 1,
  parameter int IDW = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_a,
  input  logic [N*DATA_W-1:0] req_b,
  output logic [N-1:0]        req_ready,
  output logic [DATA_W-1:0]   add_a,
  output logic [DATA_W-1:0]   add_b,
  input  logic [DATA_W-1:0]   add_y,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [DATA_W-1:0]   rsp_y,
  output logic [2:0]          inflight
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt;
  logic [PW-1:0] idx;
  logic          any;
  logic          grant;
  logic          ret;
  tag_t          new_tag;
  tag_t          last_tag;
  logic [2:0]    inflight_q, inflight_d;

  rr_grant_n #(.N(N), .PW(PW)) u_grant (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign grant     = en & any;
  assign req_ready = en ? gnt : '0;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (grant) begin
      add_a = req_a[idx*DATA_W +: DATA_W];
      add_b = req_b[idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant)
      ptr_d = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
  end

  always_comb begin
    new_tag          = '0;
    new_tag.vld      = grant;
    new_tag.id[PW-1:0] = idx;
  end

  generate
    if (LAT == 0) begin : g_comb
      assign last_tag = new_tag;
    end else begin : g_pipe
      tag_t tag_q [LAT];
      tag_t tag_d [LAT];

      always_comb begin
        tag_d[0] = new_tag;
        for (int k = 1; k < LAT; k++)
          tag_d[k] = tag_q[k-1];
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < LAT; k++)
            tag_q[k] <= '0;
        end else begin
          for (int k = 0; k < LAT; k++)
            tag_q[k] <= tag_d[k];
        end
      end

      assign last_tag = tag_q[LAT-1];
    end
  endgenerate

  assign ret       = last_tag.vld;
  assign rsp_valid = last_tag.vld;
  assign rsp_id    = IDW'(last_tag.id);
  assign rsp_y     = add_y;

  always_comb begin
    inflight_d = inflight_q;
    if (grant && !ret)
      inflight_d = inflight_q + 3'd1;
    else if (!grant && ret)
      inflight_d = inflight_q - 3'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;
endmodule

// File: tb/tb_add_i8_rr_sched.sv
// Bench: scheduler with a 1-cycle adder model,
// directed vectors and a response scoreboard.
module tb_add_i8_rr_sched;
  logic        clock;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [7:0]  add_y;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_y;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  add_i8_rr_sched #(.N(4), .LAT(1), .IDW(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .inflight  (inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) add_y <= add_a + add_b;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int y);
    exp_q.push_back({3'(id), 8'(y)});
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d y=%0d expected none",
                 rsp_id, rsp_y);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[10:8]));
        chk("rsp_y", 32'(rsp_y), 32'(e[7:0]));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_inflight", 32'(inflight), 0);
      chk("idle_add_ab", {16'h0, add_a, add_b}, 0);
      chk("idle_ready", 32'(req_ready), 0);
    end

    // all four requesting: a=i+1, b=2
    step();
    en = 1'b1;
    req_valid = 4'hf;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd2, 8'd2, 8'd2, 8'd2};
    for (int k = 0; k < 16; k++) begin
      if (k != 0) step();
      push(k % 4, (k % 4) + 3);
      @(negedge clock);
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
    end
    step();
    req_valid = '0;

    // single requester 1: 9+3
    step();
    req_valid = 4'b0010;
    req_a = {8'd0, 8'd0, 8'd9, 8'd0};
    req_b = {8'd0, 8'd0, 8'd3, 8'd0};
    push(1, 12);
    @(negedge clock);
    chk("single_ready", 32'(req_ready), 32'h2);
    chk("single_add_a", 32'(add_a), 9);
    chk("single_add_b", 32'(add_b), 3);
    step();
    req_valid = '0;
    @(negedge clock);
    chk("single_inflight", 32'(inflight), 1);

    // wrap-around results
    step();
    req_valid = 4'b0100;
    req_a = {8'd255, 8'd250, 8'd0, 8'd0};
    req_b = {8'd1, 8'd10, 8'd0, 8'd0};
    push(2, 4);
    @(negedge clock);
    chk("wrap_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b1000;
    push(3, 0);
    @(negedge clock);
    chk("wrap_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;

    // en low: no grants, pointer must hold at 0
    step();
    en = 1'b0;
    req_valid = 4'b0101;
    req_a = {8'd0, 8'd20, 8'd0, 8'd7};
    req_b = {8'd0, 8'd30, 8'd0, 8'd8};
    for (int c = 0; c < 3; c++) begin
      if (c != 0) step();
      @(negedge clock);
      chk("en0_ready", 32'(req_ready), 0);
      chk("en0_add_a", 32'(add_a), 0);
    end
    step();
    en = 1'b1;
    push(0, 15);
    @(negedge clock);
    chk("en1_first", 32'(req_ready), 32'h1);
    step();
    push(2, 50);
    @(negedge clock);
    chk("en1_second", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;

    // reset while an op is in flight
    step();
    req_valid = 4'b0010;
    req_a = {8'd0, 8'd0, 8'd1, 8'd40};
    req_b = {8'd0, 8'd0, 8'd1, 8'd2};
    @(negedge clock);
    chk("rst_pre_ready", 32'(req_ready), 32'h2);
    step();
    reset = 1'b0;
    req_valid = '0;
    @(negedge clock);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_inflight", 32'(inflight), 0);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_post_inflight", 32'(inflight), 0);
    step();
    req_valid = 4'b0101;
    req_a = {8'd0, 8'd5, 8'd0, 8'd40};
    req_b = {8'd0, 8'd5, 8'd0, 8'd2};
    push(0, 42);
    @(negedge clock);
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;

    // drain with a bounded wait
    for (int c = 0; c < 10 && exp_q.size() != 0; c++)
      @(negedge clock);
    #1;
    chk("drain_queue", 32'(exp_q.size()), 0);
    @(negedge clock);
    chk("drain_inflight", 32'(inflight), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
